// File: rtl/amp_pkg.sv
// Shared definitions for the amplitude phase sweep engine: phase codes, FSM states
// and the effective-code helper.
package amp_pkg;

    localparam logic [1:0] PH_P1 = 2'd0;
    localparam logic [1:0] PH_PI = 2'd1;
    localparam logic [1:0] PH_M1 = 2'd2;
    localparam logic [1:0] PH_MI = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Dividing by i^c is multiplying by i^(-c), so the inverse code is -c mod 4.
    function automatic logic [1:0] eff_code(input logic [1:0] code, input logic divide);
        return divide ? (2'd0 - code) : code;
    endfunction

endpackage

// File: rtl/amp_phase_rotate.sv
// Combinational rotation of one complex lane by i^code, with saturating negation.
module amp_phase_rotate
    import amp_pkg::*;
#(
    parameter int unsigned CW = 24
) (
    input  logic [1:0]    code,
    input  logic [CW-1:0] a_re,
    input  logic [CW-1:0] a_im,
    output logic [CW-1:0] y_re,
    output logic [CW-1:0] y_im
);

    localparam logic [CW-1:0] MIN_V = {1'b1, {(CW - 1) {1'b0}}};
    localparam logic [CW-1:0] MAX_V = ~MIN_V;

    // The most negative value has no positive twin; clamp it to the maximum.
    function automatic logic [CW-1:0] sat_neg(input logic [CW-1:0] x);
        return (x == MIN_V) ? MAX_V : (~x + CW'(1));
    endfunction

    always_comb begin
        y_re = a_re;
        y_im = a_im;
        case (code)
            PH_PI: begin
                y_re = sat_neg(a_im);
                y_im = a_re;
            end
            PH_M1: begin
                y_re = sat_neg(a_re);
                y_im = sat_neg(a_im);
            end
            PH_MI: begin
                y_re = a_im;
                y_im = sat_neg(a_re);
            end
            default: begin
                y_re = a_re;
                y_im = a_im;
            end
        endcase
    end

endmodule

// File: rtl/amplitude_phase_sweep.sv
// Read-modify-write sweep over an amplitude RAM, rotating every lane of every word
// by a global phase latched at start.
module amplitude_phase_sweep
    import amp_pkg::*;
#(
    parameter int unsigned CW     = 24,
    parameter int unsigned LANES  = 1,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              phase_code,
    input  logic                    divide,
    input  logic [ADDR_W:0]         count,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [LANES*2*CW-1:0]   rd_data,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [LANES*2*CW-1:0]   wr_data,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned WORD_W = 2 * CW;
    localparam int unsigned DATA_W = LANES * WORD_W;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);

    state_t              state;
    state_t              state_next;
    logic                rd_en_next;
    logic [ADDR_W-1:0]   rd_addr_next;
    logic                load;
    logic [1:0]          phase_q;
    logic [CNT_W-1:0]    count_q;
    logic [RD_LAT-1:0]   vld;
    logic [ADDR_W-1:0]   addr_pipe [RD_LAT];
    logic [DATA_W-1:0]   rot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state plus the read-side strobe/address that will be registered.
    always_comb begin
        state_next   = state;
        rd_en_next   = 1'b0;
        rd_addr_next = rd_addr;
        load         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (count == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next   = READ;
                        rd_en_next   = 1'b1;
                        rd_addr_next = '0;
                    end
                end
            end
            READ: begin
                if (CNT_W'(rd_addr) == count_q - CNT_W'(1)) begin
                    state_next = DRAIN;
                end else begin
                    rd_en_next   = 1'b1;
                    rd_addr_next = rd_addr + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (vld == '0) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            phase_q <= PH_P1;
            count_q <= '0;
        end else begin
            rd_en   <= rd_en_next;
            rd_addr <= rd_addr_next;
            busy    <= (state_next != IDLE);
            done    <= (state_next == DONE);
            if (load) begin
                phase_q <= eff_code(phase_code, divide);
                count_q <= (count > DEPTH) ? DEPTH : count;
            end
        end
    end

    // Valid/address stages matching the RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) addr_pipe[i] <= '0;
        end else begin
            vld[0]       <= rd_en;
            addr_pipe[0] <= rd_addr;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld[i]       <= vld[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
        amp_phase_rotate #(
            .CW(CW)
        ) u_rot (
            .code (phase_q),
            .a_re (rd_data[(k+1)*WORD_W-1 -: CW]),
            .a_im (rd_data[k*WORD_W+CW-1 -: CW]),
            .y_re (rot[(k+1)*WORD_W-1 -: CW]),
            .y_im (rot[k*WORD_W+CW-1 -: CW])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= vld[RD_LAT-1];
            if (vld[RD_LAT-1]) begin
                wr_addr <= addr_pipe[RD_LAT-1];
                wr_data <= rot;
            end
        end
    end

endmodule

// File: tb/tb_amplitude_phase_sweep.sv
// Self-checking bench: two engine instances (1 lane / latency 1, 4 lanes / latency 3)
// against RAM models and a complex-multiply reference.
module tb_amplitude_phase_sweep;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_a = 1'b0;
    logic         start_b = 1'b0;
    logic [1:0]   phase_code = 2'd0;
    logic         divide = 1'b0;
    logic [4:0]   count = 5'd0;

    logic         rd_en_a, wr_en_a, busy_a, done_a;
    logic [3:0]   rd_addr_a, wr_addr_a;
    logic [47:0]  rd_data_a, wr_data_a;
    logic         rd_en_b, wr_en_b, busy_b, done_b;
    logic [3:0]   rd_addr_b, wr_addr_b;
    logic [191:0] rd_data_b, wr_data_b, b_d1, b_d2;

    logic [47:0]  mem_a [16];
    logic [191:0] mem_b [16];
    logic         host_we = 1'b0;
    logic         host_sel = 1'b0;
    logic [3:0]   host_addr = 4'd0;
    logic [191:0] host_data = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic cur = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    amplitude_phase_sweep #(.CW(24), .LANES(1), .ADDR_W(4), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .phase_code(phase_code), .divide(divide),
        .count(count), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .busy(busy_a), .done(done_a));

    amplitude_phase_sweep #(.CW(24), .LANES(4), .ADDR_W(4), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .phase_code(phase_code), .divide(divide),
        .count(count), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b), .done(done_b));

    // RAM models: A has one cycle of read latency, B three.
    always @(posedge clk) begin
        if (host_we) begin
            if (host_sel) mem_b[host_addr] <= host_data;
            else          mem_a[host_addr] <= host_data[47:0];
        end
        if (wr_en_a) mem_a[wr_addr_a] <= wr_data_a;
        if (wr_en_b) mem_b[wr_addr_b] <= wr_data_b;
        rd_data_a <= mem_a[rd_addr_a];
        b_d1      <= mem_b[rd_addr_b];
        b_d2      <= b_d1;
        rd_data_b <= b_d2;
    end

    logic         rd_en_s, wr_en_s, busy_s, done_s;
    logic [3:0]   rd_addr_s, wr_addr_s;
    logic [191:0] wr_data_s;
    assign rd_en_s   = cur ? rd_en_b   : rd_en_a;
    assign wr_en_s   = cur ? wr_en_b   : wr_en_a;
    assign busy_s    = cur ? busy_b    : busy_a;
    assign done_s    = cur ? done_b    : done_a;
    assign rd_addr_s = cur ? rd_addr_b : rd_addr_a;
    assign wr_addr_s = cur ? wr_addr_b : wr_addr_a;
    assign wr_data_s = cur ? wr_data_b : {144'd0, wr_data_a};

    function automatic longint sat24(input longint v);
        if (v > 64'sd8388607)  return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    // Multiply each lane by the unit phase c+di (its conjugate when dividing).
    function automatic logic [191:0] rot_word(input logic [191:0] w, input int lanes,
                                              input logic [1:0] code, input logic div);
        logic [191:0] r;
        longint c, d, re, im;
        r = '0;
        case (code)
            2'd0:    begin c = 1;  d = 0;  end
            2'd1:    begin c = 0;  d = 1;  end
            2'd2:    begin c = -1; d = 0;  end
            default: begin c = 0;  d = -1; end
        endcase
        if (div) d = -d;
        for (int k = 0; k < lanes; k++) begin
            re = longint'($signed(w[k*48+24 +: 24]));
            im = longint'($signed(w[k*48 +: 24]));
            r[k*48+24 +: 24] = 24'(sat24(c * re - d * im));
            r[k*48 +: 24]    = 24'(sat24(d * re + c * im));
        end
        return r;
    endfunction

    function automatic logic [191:0] mem_word(input logic sel, input int a);
        return sel ? mem_b[4'(a)] : {144'd0, mem_a[4'(a)]};
    endfunction

    task automatic load_word(input logic sel, input int a, input logic [191:0] data);
        @(negedge clk);
        host_we = 1'b1; host_sel = sel; host_addr = 4'(a); host_data = data;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    // One sweep with cycle-by-cycle checks of strobes, addresses, data, busy and done.
    task automatic run_sweep(input logic sel, input logic [1:0] code, input logic div,
                             input int cnt, input int inject, output int done_rel, output int nwr);
        logic [191:0] expw [16];
        int lat, lanes, ncnt, dexp, rel, wa, t0;
        logic exp_rd, exp_wr;
        cur = sel;
        lat = sel ? 3 : 1;
        lanes = sel ? 4 : 1;
        ncnt = (cnt > 16) ? 16 : cnt;
        for (int a = 0; a < 16; a++)
            expw[a] = (a < ncnt) ? rot_word(mem_word(sel, a), lanes, code, div) : mem_word(sel, a);
        dexp = (ncnt == 0) ? 1 : ncnt + lat + 2;
        done_rel = -1;
        nwr = 0;
        @(negedge clk);
        phase_code = code; divide = div; count = 5'(cnt);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        t0 = cyc;
        for (int k = 0; k < dexp + 4; k++) begin
            @(negedge clk);
            rel = cyc - t0;
            start_a = 1'b0; start_b = 1'b0;
            if (rel == inject) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
                phase_code = ~code; divide = ~div; count = 5'(cnt + 1);
            end
            exp_rd = (rel >= 1) && (rel <= ncnt);
            n_cmp++;
            if (rd_en_s !== exp_rd) begin
                n_err++; $display("FAIL rd_en sel=%0d rel=%0d got %b want %b", sel, rel, rd_en_s, exp_rd);
            end
            if (exp_rd || (ncnt > 0 && rel > ncnt)) begin
                wa = exp_rd ? rel - 1 : ncnt - 1;
                n_cmp++;
                if (rd_addr_s !== 4'(wa)) begin
                    n_err++; $display("FAIL rd_addr sel=%0d rel=%0d got %0d want %0d", sel, rel, rd_addr_s, wa);
                end
            end
            exp_wr = (ncnt > 0) && (rel >= lat + 2) && (rel <= ncnt + lat + 1);
            if (wr_en_s === 1'b1) nwr++;
            n_cmp++;
            if (wr_en_s !== exp_wr) begin
                n_err++; $display("FAIL wr_en sel=%0d rel=%0d got %b want %b", sel, rel, wr_en_s, exp_wr);
            end
            if (exp_wr || (ncnt > 0 && rel > ncnt + lat + 1)) begin
                wa = exp_wr ? rel - lat - 2 : ncnt - 1;
                n_cmp++;
                if (wr_addr_s !== 4'(wa)) begin
                    n_err++; $display("FAIL wr_addr sel=%0d rel=%0d got %0d want %0d", sel, rel, wr_addr_s, wa);
                end
                if (exp_wr) begin
                    n_cmp++;
                    if (wr_data_s !== expw[wa]) begin
                        n_err++; $display("FAIL wr_data sel=%0d addr=%0d got %h want %h", sel, wa, wr_data_s, expw[wa]);
                    end
                end
            end
            n_cmp++;
            if (busy_s !== ((rel >= 1) && (rel <= dexp))) begin
                n_err++; $display("FAIL busy sel=%0d rel=%0d got %b", sel, rel, busy_s);
            end
            n_cmp++;
            if (done_s !== (rel == dexp)) begin
                n_err++; $display("FAIL done sel=%0d rel=%0d got %b want %b", sel, rel, done_s, rel == dexp);
            end
            if (done_s === 1'b1 && done_rel < 0) done_rel = rel;
        end
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (mem_word(sel, a) !== expw[a]) begin
                n_err++; $display("FAIL mem sel=%0d addr=%0d got %h want %h", sel, a, mem_word(sel, a), expw[a]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rd_en_a, rd_addr_a, wr_en_a, wr_addr_a, wr_data_a, busy_a, done_a} !== '0) begin
            n_err++; $display("FAIL reset_a outputs not zero: rd_en=%b wr_en=%b busy=%b done=%b", rd_en_a, wr_en_a, busy_a, done_a);
        end
        n_cmp++;
        if ({rd_en_b, rd_addr_b, wr_en_b, wr_addr_b, wr_data_b, busy_b, done_b} !== '0) begin
            n_err++; $display("FAIL reset_b outputs not zero: rd_en=%b wr_en=%b busy=%b done=%b", rd_en_b, wr_en_b, busy_b, done_b);
        end
        rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            load_word(1'b0, a, {$urandom, $urandom});
            load_word(1'b1, a, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        end
    endtask

    task automatic test_basic;
        int d, n;
        load_word(1'b0, 0, {24'd100, 24'(-50)});
        run_sweep(1'b0, 2'd1, 1'b0, 4, -1, d, n);
        n_cmp++;
        if (mem_a[0] !== {24'd50, 24'd100}) begin
            n_err++; $display("FAIL basic_word0 got %h want %h", mem_a[0], {24'd50, 24'd100});
        end
        n_cmp++;
        if (d !== 7) begin n_err++; $display("FAIL basic_done_cycle got %0d want 7", d); end
    endtask

    task automatic test_codes;
        int d, n;
        logic [47:0] want [3];
        logic [1:0]  codes [3];
        logic        divs [3];
        want[0] = {24'(-50), 24'(-100)}; codes[0] = 2'd1; divs[0] = 1'b1;
        want[1] = {24'(-100), 24'd50};   codes[1] = 2'd2; divs[1] = 1'b0;
        want[2] = {24'd100, 24'(-50)};   codes[2] = 2'd0; divs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_word(1'b0, 0, {24'd100, 24'(-50)});
            run_sweep(1'b0, codes[i], divs[i], 4, -1, d, n);
            n_cmp++;
            if (mem_a[0] !== want[i]) begin
                n_err++; $display("FAIL code_%0d got %h want %h", i, mem_a[0], want[i]);
            end
        end
    endtask

    task automatic test_saturation;
        int d, n;
        load_word(1'b0, 0, {24'h800000, 24'd5});
        run_sweep(1'b0, 2'd2, 1'b0, 1, -1, d, n);
        n_cmp++;
        if (mem_a[0] !== {24'h7FFFFF, 24'(-5)}) begin
            n_err++; $display("FAIL sat_neg_re got %h want %h", mem_a[0], {24'h7FFFFF, 24'(-5)});
        end
        load_word(1'b0, 1, {24'd7, 24'h800000});
        run_sweep(1'b0, 2'd1, 1'b0, 2, -1, d, n);
        n_cmp++;
        if (mem_a[1] !== {24'h7FFFFF, 24'd7}) begin
            n_err++; $display("FAIL sat_neg_im got %h want %h", mem_a[1], {24'h7FFFFF, 24'd7});
        end
    endtask

    task automatic test_count_edges;
        int d, n;
        run_sweep(1'b0, 2'd3, 1'b0, 0, -1, d, n);
        n_cmp++;
        if (d !== 1 || n !== 0) begin n_err++; $display("FAIL count0 done=%0d writes=%0d want 1/0", d, n); end
        run_sweep(1'b0, 2'd1, 1'b1, 16, -1, d, n);
        n_cmp++;
        if (n !== 16) begin n_err++; $display("FAIL count16_writes got %0d want 16", n); end
        run_sweep(1'b0, 2'd2, 1'b0, 25, -1, d, n);
        n_cmp++;
        if (n !== 16 || d !== 19) begin n_err++; $display("FAIL count_clamp writes=%0d done=%0d want 16/19", n, d); end
    endtask

    task automatic test_multilane;
        int d, n;
        logic [191:0] want;
        load_word(1'b1, 0, {24'h800000, 24'd3, 24'd7, 24'h800000, 24'(-9), 24'd11, 24'd0, 24'h7FFFFF});
        want = {24'd3, 24'h7FFFFF, 24'h800000, 24'(-7), 24'd11, 24'd9, 24'h7FFFFF, 24'd0};
        run_sweep(1'b1, 2'd3, 1'b0, 3, 2, d, n);
        n_cmp++;
        if (mem_b[0] !== want) begin n_err++; $display("FAIL lanes_word0 got %h want %h", mem_b[0], want); end
        n_cmp++;
        if (d !== 8 || n !== 3) begin n_err++; $display("FAIL lanes_timing done=%0d writes=%0d want 8/3", d, n); end
    endtask

    task automatic test_reset_mid;
        logic [47:0] snap [16];
        int d, n;
        cur = 1'b0;
        for (int a = 0; a < 16; a++) snap[a] = mem_a[a];
        @(negedge clk);
        phase_code = 2'd1; divide = 1'b0; count = 5'd8; start_a = 1'b1;
        repeat (3) begin @(negedge clk); start_a = 1'b0; end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({rd_en_a, rd_addr_a, wr_en_a, wr_addr_a, wr_data_a, busy_a, done_a} !== '0) begin
            n_err++; $display("FAIL midreset_outputs rd_en=%b wr_en=%b busy=%b wr_data=%h", rd_en_a, wr_en_a, busy_a, wr_data_a);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (wr_en_a !== 1'b0 || rd_en_a !== 1'b0 || busy_a !== 1'b0) begin
                n_err++; $display("FAIL midreset_idle k=%0d wr_en=%b rd_en=%b busy=%b", k, wr_en_a, rd_en_a, busy_a);
            end
        end
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (mem_a[a] !== snap[a]) begin
                n_err++; $display("FAIL midreset_mem addr=%0d got %h want %h", a, mem_a[a], snap[a]);
            end
        end
        run_sweep(1'b0, 2'd1, 1'b0, 8, -1, d, n);
        n_cmp++;
        if (n !== 8) begin n_err++; $display("FAIL midreset_resweep writes=%0d want 8", n); end
    endtask

    task automatic test_random;
        int d, n;
        for (int i = 0; i < 8; i++) begin
            run_sweep(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 20)), int'($urandom_range(0, 6)), d, n);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_codes;
        test_saturation;
        test_count_edges;
        test_multilane;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
